// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multicycle controller.
// Holds state enum, condition codes, class patterns, mux encodings, opcodes.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH   = 4'd0,
      ST_DECODE  = 4'd1,
      ST_BR      = 4'd2,
      ST_LS_ADDR = 4'd3,
      ST_LD_MEM  = 4'd4,
      ST_LD_WB   = 4'd5,
      ST_ST_MEM  = 4'd6,
      ST_DP_EXEC = 4'd7,
      ST_DP_WB   = 4'd8,
      ST_FAULT   = 4'd9
   } state_e;

   typedef enum logic [1:0] {
      COND_EQ = 2'b00,
      COND_GT = 2'b01,
      COND_LT = 2'b10,
      COND_AL = 2'b11
   } cond_e;

   // ALU operation source: fixed add or the instruction opcode
   typedef enum logic {
      AOP_ADD  = 1'b0,
      AOP_FUNC = 1'b1
   } alu_op_e;

   // class patterns: BR on [29:27], LS on [29:21], DP on [29:24]
   localparam logic [2:0] BR_CLASS = 3'b101;
   localparam logic [8:0] LS_CLASS = 9'b010000000;
   localparam logic [5:0] DP_CLASS = 6'b000000;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_OFFSET = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_FOUR   = 2'b11;

   localparam logic [1:0] M2R_MEM = 2'b00;
   localparam logic [1:0] M2R_PC  = 2'b01;
   localparam logic [1:0] M2R_ALU = 2'b10;

   localparam int OP_ADD = 0;
   localparam int OP_SUB = 1;
   localparam int OP_CMP = 6;
   localparam int OP_TST = 7;

   function automatic logic cond_pass(
      input cond_e cc,
      input logic  z,
      input logic  n,
      input logic  v
   );
      logic ok;
      case (cc)
         COND_EQ: ok = z;
         COND_GT: ok = !z && (n == v);
         COND_LT: ok = (n != v);
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mc_alu_flag_decode.sv
// mc_alu_flag_decode: ALU function select, flag write enables, R-type permit.
// In: alu_op, flag_en, opcode. Out: alu_operation, z/n/v/c_write, rtype_write_ok.
module mc_alu_flag_decode import mc_ctrl_pkg::*; #(
   parameter int ALU_OP_W = 3
) (
   input  alu_op_e             alu_op,
   input  logic                flag_en,
   input  logic [ALU_OP_W-1:0] opcode,
   output logic [ALU_OP_W-1:0] alu_operation,
   output logic                z_write,
   output logic                n_write,
   output logic                v_write,
   output logic                c_write,
   output logic                rtype_write_ok
);

   logic arith_op;
   logic cmp_op;

   always_comb begin
      // only add/sub/compare produce meaningful overflow and carry
      arith_op = (opcode == ALU_OP_W'(OP_ADD)) ||
                 (opcode == ALU_OP_W'(OP_SUB)) ||
                 (opcode == ALU_OP_W'(OP_CMP));
      cmp_op   = (opcode == ALU_OP_W'(OP_CMP)) ||
                 (opcode == ALU_OP_W'(OP_TST));

      alu_operation  = (alu_op == AOP_FUNC) ? opcode : '0;
      z_write        = flag_en;
      n_write        = flag_en;
      v_write        = flag_en && arith_op;
      c_write        = flag_en && arith_op;
      rtype_write_ok = !cmp_op;
   end

endmodule

// File: rtl/mc_controller_v2.sv
// mc_controller_v2: multicycle control unit with ready/valid memory handshake.
// Ports: Clk, Rst (sync, high), Instruction, Z/N/V/C, MemReady in; datapath
// controls, write enables, ALUOperation, MemRead/MemWrite, Illegal, Fault out.
// Build option: MC_CTRL_MEM_WATCHDOG_EN enables the memory wait watchdog.
module mc_controller_v2 import mc_ctrl_pkg::*; #(
   parameter int INSTR_W     = 32,
   parameter int ALU_OP_W    = 3,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic [INSTR_W-1:0]  Instruction,
   input  logic                Z,
   input  logic                N,
   input  logic                V,
   input  logic                C,
   input  logic                MemReady,
   output logic                PCWrite,
   output logic                IRWrite,
   output logic                IorD,
   output logic                RegSel,
   output logic                RegDst,
   output logic                PCSrc,
   output logic                ALUSrcA,
   output logic [1:0]          MemToReg,
   output logic [1:0]          ALUSrcB,
   output logic                RegWrite,
   output logic                ZWrite,
   output logic                NWrite,
   output logic                VWrite,
   output logic                CWrite,
   output logic [ALU_OP_W-1:0] ALUOperation,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                Illegal,
   output logic                Fault
);

   // position of instruction bit 20 (bottom of the decoded 12-bit field)
   localparam int F = INSTR_W - 12;

   state_e state_q, state_d;

   cond_e               f_cond;
   logic [8:0]          f_class;
   logic                f_ls;
   logic                f_imm;
   logic                f_link;
   logic [ALU_OP_W-1:0] f_opcode;

   assign f_cond   = cond_e'(Instruction[F+11:F+10]);
   assign f_class  = Instruction[F+9:F+1];
   assign f_ls     = Instruction[F];
   assign f_imm    = Instruction[F+3];
   assign f_link   = Instruction[F+6];
   assign f_opcode = Instruction[F +: ALU_OP_W];

   // C is carried for future conditions; low instruction bits are datapath-only
   logic unused_inputs;
   assign unused_inputs = ^{C, Instruction};

   logic       pc_write, ir_write, iord, reg_sel;
   logic       reg_dst, pc_src, alu_src_a;
   logic [1:0] mem_to_reg, alu_src_b;
   logic       reg_write, mem_read, mem_write, illegal;
   alu_op_e    alu_op;
   logic       flag_en;
   logic       timeout;

   logic [ALU_OP_W-1:0] alu_operation;
   logic                z_we, n_we, v_we, c_we;
   logic                rtype_ok;

   mc_alu_flag_decode #(
      .ALU_OP_W (ALU_OP_W)
   ) u_flag_dec (
      .alu_op         (alu_op),
      .flag_en        (flag_en),
      .opcode         (f_opcode),
      .alu_operation  (alu_operation),
      .z_write        (z_we),
      .n_write        (n_we),
      .v_write        (v_we),
      .c_write        (c_we),
      .rtype_write_ok (rtype_ok)
   );

   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      reg_sel    = 1'b0;
      reg_dst    = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = 1'b0;
      mem_to_reg = M2R_MEM;
      alu_src_b  = SRCB_REG;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      illegal    = 1'b0;
      alu_op     = AOP_ADD;
      flag_en    = 1'b0;

      case (state_q)
         ST_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (MemReady) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = ST_DECODE;
            end else if (timeout) begin
               state_d = ST_FAULT;
            end
         end
         ST_DECODE: begin
            alu_src_b = SRCB_OFFSET;
            if (!cond_pass(f_cond, Z, N, V)) begin
               state_d = ST_FETCH;
            end else if (f_class[8:6] == BR_CLASS) begin
               state_d = ST_BR;
            end else if (f_class == LS_CLASS) begin
               state_d = ST_LS_ADDR;
            end else if (f_class[8:3] == DP_CLASS) begin
               state_d = ST_DP_EXEC;
            end else begin
               illegal = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_BR: begin
            pc_src   = 1'b1;
            pc_write = 1'b1;
            if (f_link) begin
               reg_dst    = 1'b1;
               mem_to_reg = M2R_PC;
               reg_write  = 1'b1;
            end
            state_d = ST_FETCH;
         end
         ST_LS_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            reg_sel   = f_ls;
            state_d   = f_ls ? ST_ST_MEM : ST_LD_MEM;
         end
         ST_LD_MEM: begin
            iord     = 1'b1;
            mem_read = 1'b1;
            if (MemReady) begin
               state_d = ST_LD_WB;
            end else if (timeout) begin
               state_d = ST_FAULT;
            end
         end
         ST_ST_MEM: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (MemReady) begin
               state_d = ST_FETCH;
            end else if (timeout) begin
               state_d = ST_FAULT;
            end
         end
         ST_LD_WB: begin
            mem_to_reg = M2R_MEM;
            reg_write  = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_DP_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = f_imm ? SRCB_IMM : SRCB_REG;
            alu_op    = AOP_FUNC;
            flag_en   = 1'b1;
            state_d   = ST_DP_WB;
         end
         ST_DP_WB: begin
            mem_to_reg = M2R_ALU;
            reg_write  = rtype_ok;
            state_d    = ST_FETCH;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef MC_CTRL_MEM_WATCHDOG_EN
   logic [7:0] wait_q, wait_d;
   logic [7:0] wait_inc;
   logic       fault_q, fault_d;
   logic       mem_state;
   logic       stalled;

   always_comb begin
      mem_state = (state_q == ST_FETCH) ||
                  (state_q == ST_LD_MEM) ||
                  (state_q == ST_ST_MEM);
      stalled   = mem_state && !MemReady;
      wait_inc  = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
      // this cycle's wait is included, so TIMEOUT_CYC stalled cycles trip it
      timeout   = stalled && (int'(wait_inc) >= TIMEOUT_CYC);
      wait_d    = (stalled && (state_d == state_q)) ? wait_inc : 8'd0;
      fault_d   = fault_q || timeout;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wait_q  <= 8'd0;
         fault_q <= 1'b0;
      end else begin
         wait_q  <= wait_d;
         fault_q <= fault_d;
      end
   end

   assign Fault = fault_q & ~Rst;
`else
   assign timeout = 1'b0;
   assign Fault   = 1'b0;
`endif

   // reset forces every strobe low, including the fetch read
   assign PCWrite      = pc_write  & ~Rst;
   assign IRWrite      = ir_write  & ~Rst;
   assign IorD         = iord      & ~Rst;
   assign RegSel       = reg_sel   & ~Rst;
   assign RegDst       = reg_dst   & ~Rst;
   assign PCSrc        = pc_src    & ~Rst;
   assign ALUSrcA      = alu_src_a & ~Rst;
   assign MemToReg     = Rst ? 2'b00 : mem_to_reg;
   assign ALUSrcB      = Rst ? 2'b00 : alu_src_b;
   assign RegWrite     = reg_write & ~Rst;
   assign ZWrite       = z_we      & ~Rst;
   assign NWrite       = n_we      & ~Rst;
   assign VWrite       = v_we      & ~Rst;
   assign CWrite       = c_we      & ~Rst;
   assign ALUOperation = Rst ? '0 : alu_operation;
   assign MemRead      = mem_read  & ~Rst;
   assign MemWrite     = mem_write & ~Rst;
   assign Illegal      = illegal   & ~Rst;

endmodule

// File: tb/tb_mc_controller_v2.sv
// tb_mc_controller_v2: vector table, corner sequences and random instructions
// checked cycle by cycle against a transaction-level controller model.
module tb_mc_controller_v2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = '0;
   logic        z = 1'b0, n = 1'b0, v = 1'b0, c = 1'b0;
   logic        rdy = 1'b0;

   logic       PCWrite, IRWrite, IorD, RegSel, RegDst, PCSrc, ALUSrcA;
   logic [1:0] MemToReg, ALUSrcB;
   logic       RegWrite, ZWrite, NWrite, VWrite, CWrite;
   logic [2:0] ALUOperation;
   logic       MemRead, MemWrite, Illegal, Fault;

   mc_controller_v2 dut (
      .Clk(clk), .Rst(rst), .Instruction(instr),
      .Z(z), .N(n), .V(v), .C(c), .MemReady(rdy),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
      .RegSel(RegSel), .RegDst(RegDst), .PCSrc(PCSrc),
      .ALUSrcA(ALUSrcA), .MemToReg(MemToReg), .ALUSrcB(ALUSrcB),
      .RegWrite(RegWrite), .ZWrite(ZWrite), .NWrite(NWrite),
      .VWrite(VWrite), .CWrite(CWrite), .ALUOperation(ALUOperation),
      .MemRead(MemRead), .MemWrite(MemWrite),
      .Illegal(Illegal), .Fault(Fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcw, irw, iord, regsel, regdst, pcsrc, srca;
      logic [1:0] m2r, srcb;
      logic       rw, zw, nw, vw, cw;
      logic [2:0] aop;
      logic       mr, mw, ill, flt;
   } outs_t;

   outs_t got;
   assign got = {PCWrite, IRWrite, IorD, RegSel, RegDst, PCSrc, ALUSrcA,
                 MemToReg, ALUSrcB, RegWrite, ZWrite, NWrite, VWrite,
                 CWrite, ALUOperation, MemRead, MemWrite, Illegal, Fault};

   typedef struct {
      logic  r;
      outs_t e;
   } step_t;

   typedef struct {
      logic [31:0] ins;
      logic [3:0]  f;
      int          fw;
      int          mw;
      int          rw;
      int          ill;
      string       nm;
   } vec_t;

   step_t q[$];
   vec_t  tbl[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    obs_rw, obs_ill;

   function automatic logic rbit();
      return 1'($urandom);
   endfunction

   function automatic outs_t o_fetch(input logic r);
      outs_t o = '0;
      o.mr = 1'b1; o.srcb = 2'd3; o.pcw = r; o.irw = r;
      return o;
   endfunction

   function automatic outs_t o_mem(input logic st);
      outs_t o = '0;
      o.iord = 1'b1; o.mw = st; o.mr = !st;
      return o;
   endfunction

   function automatic outs_t o_lsaddr(input logic st);
      outs_t o = '0;
      o.srca = 1'b1; o.srcb = 2'd2; o.regsel = st;
      return o;
   endfunction

   function automatic outs_t o_decode(input logic il);
      outs_t o = '0;
      o.srcb = 2'd1; o.ill = il;
      return o;
   endfunction

   function automatic logic cond_true(input logic [1:0] cd,
                                      input logic fz, fn, fv);
      case (cd)
         2'd0:    return fz;
         2'd1:    return !fz && (fn == fv);
         2'd2:    return fn != fv;
         default: return 1'b1;
      endcase
   endfunction

   task automatic push(input logic r, input outs_t o);
      step_t s;
      s.r = r; s.e = o;
      q.push_back(s);
   endtask

   // expand one instruction into its expected cycle sequence
   task automatic build(input logic [31:0] ins, input logic [3:0] f,
                        input int fw, input int mw);
      outs_t o;
      logic [2:0] op;
      logic br, ls, dp, st;
      q.delete();
      repeat (fw) push(1'b0, o_fetch(1'b0));
      push(1'b1, o_fetch(1'b1));
      br = (ins[29:27] == 3'b101);
      ls = (ins[29:21] == 9'b010000000);
      dp = (ins[29:24] == 6'd0);
      op = ins[22:20];
      st = ins[20];
      if (!cond_true(ins[31:30], f[3], f[2], f[1])) begin
         push(rbit(), o_decode(1'b0));
         return;
      end
      if (!br && !ls && !dp) begin
         push(rbit(), o_decode(1'b1));
         return;
      end
      push(rbit(), o_decode(1'b0));
      if (br) begin
         o = '0; o.pcsrc = 1'b1; o.pcw = 1'b1;
         if (ins[26]) begin
            o.regdst = 1'b1; o.m2r = 2'd1; o.rw = 1'b1;
         end
         push(rbit(), o);
      end else if (ls) begin
         push(rbit(), o_lsaddr(st));
         repeat (mw) push(1'b0, o_mem(st));
         push(1'b1, o_mem(st));
         if (!st) begin
            o = '0; o.rw = 1'b1;
            push(rbit(), o);
         end
      end else begin
         o = '0; o.srca = 1'b1; o.srcb = ins[23] ? 2'd2 : 2'd0;
         o.aop = op; o.zw = 1'b1; o.nw = 1'b1;
         o.vw = (op == 3'd0) || (op == 3'd1) || (op == 3'd6);
         o.cw = o.vw;
         push(rbit(), o);
         o = '0; o.m2r = 2'd2; o.rw = (op < 3'd6);
         push(rbit(), o);
      end
   endtask

   task automatic check_outs(input outs_t e, input string nm);
      n_cmp++;
      if (got !== e) begin
         n_bad++;
         $display("FAIL %s: got=%06h exp=%06h", nm, got, e);
      end
   endtask

   // called just after a rising edge; samples on the falling edge
   task automatic cyc(input logic r, input outs_t e, input string nm);
      rdy = r;
      @(negedge clk);
      check_outs(e, nm);
      obs_rw  += int'(got.rw);
      obs_ill += int'(got.ill);
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [31:0] ins, input logic [3:0] f,
                            input int fw, input int mw, input string nm);
      instr = ins;
      {z, n, v, c} = f;
      build(ins, f, fw, mw);
      obs_rw = 0;
      obs_ill = 0;
      foreach (q[i]) cyc(q[i].r, q[i].e, nm);
   endtask

   task automatic add(input logic [31:0] ins, input logic [3:0] f,
                      input int fw, input int mw, input int rw,
                      input int ill, input string nm);
      vec_t t;
      t.ins = ins; t.f = f; t.fw = fw; t.mw = mw;
      t.rw = rw; t.ill = ill; t.nm = nm;
      tbl.push_back(t);
   endtask

   initial begin
      logic [31:0] ri;
      outs_t       flt_o;

      // flags are {Z,N,V,C}
      add(32'h1000_0000, 4'b1000, 0, 3, 1, 0, "load_eq_wait3");
      add(32'hEC00_0000, 4'b0000, 0, 0, 1, 0, "br_al_link");
      add(32'h2C00_0000, 4'b0000, 1, 0, 0, 0, "br_eq_skip");
      add(32'hC0E0_0000, 4'b0000, 0, 0, 0, 0, "dp_cmp_imm");
      add(32'hF800_0000, 4'b0000, 0, 0, 0, 1, "illegal");
      add(32'h3800_0000, 4'b0000, 0, 0, 0, 0, "illegal_cond_false");
      add(32'hD010_0000, 4'b0000, 2, 2, 0, 0, "store_wait2");
      add(32'hC000_0000, 4'b0000, 0, 0, 1, 0, "dp_add_reg");
      add(32'hC070_0000, 4'b0000, 0, 0, 0, 0, "dp_tst");
      add(32'hC020_0000, 4'b0000, 0, 0, 1, 0, "dp_op2");
      add(32'h5000_0000, 4'b0110, 0, 1, 1, 0, "load_gt_pass");
      add(32'h5000_0000, 4'b0100, 0, 0, 0, 0, "load_gt_fail");
      add(32'h9000_0000, 4'b0100, 0, 0, 1, 0, "load_lt_pass");
      add(32'hE800_0000, 4'b1111, 0, 0, 0, 0, "br_al_nolink");

      // reset holds every output low, even with MemReady high
      rst = 1'b1;
      cyc(1'b1, '0, "reset_c1");
      cyc(1'b1, '0, "reset_c2");
      rst = 1'b0;
      cyc(1'b0, o_fetch(1'b0), "post_reset_fetch");

      foreach (tbl[i]) begin
         run_instr(tbl[i].ins, tbl[i].f, tbl[i].fw, tbl[i].mw, tbl[i].nm);
         n_cmp++;
         if (obs_rw != tbl[i].rw || obs_ill != tbl[i].ill) begin
            n_bad++;
            $display("FAIL %s_count: rw=%0d ill=%0d exp rw=%0d ill=%0d",
                     tbl[i].nm, obs_rw, obs_ill, tbl[i].rw, tbl[i].ill);
         end
      end

      // reset during decode of a link branch: no branch writes follow
      instr = 32'hEC00_0000;
      cyc(1'b1, o_fetch(1'b1), "abort_fetch");
      rst = 1'b1;
      cyc(rbit(), '0, "abort_rst");
      rst = 1'b0;
      cyc(1'b0, o_fetch(1'b0), "abort_refetch");
      run_instr(32'hC000_0000, 4'b0000, 0, 0, "after_abort");

      // store that never gets MemReady
      instr = 32'hD010_0000;
      cyc(1'b1, o_fetch(1'b1), "wd_fetch");
      cyc(rbit(), o_decode(1'b0), "wd_decode");
      cyc(rbit(), o_lsaddr(1'b1), "wd_lsaddr");
`ifdef MC_CTRL_MEM_WATCHDOG_EN
      flt_o = '0;
      flt_o.flt = 1'b1;
      repeat (15) cyc(1'b0, o_mem(1'b1), "wd_stmem");
      repeat (4) cyc(rbit(), flt_o, "wd_fault");
      rst = 1'b1;
      cyc(rbit(), '0, "wd_rst");
      rst = 1'b0;
      cyc(1'b0, o_fetch(1'b0), "wd_refetch");
`else
      flt_o = '0;
      repeat (40) cyc(1'b0, o_mem(1'b1), "nowd_stmem");
      cyc(1'b1, o_mem(1'b1), "nowd_done");
      cyc(1'b0, o_fetch(1'b0), "nowd_fetch");
      check_outs(o_fetch(1'b0) | flt_o, "nowd_still_fetch");
`endif

      // random instructions biased toward each legal class
      for (int k = 0; k < 150; k++) begin
         ri = $urandom;
         case ($urandom_range(0, 4))
            0: ri[29:27] = 3'b101;
            1: ri[29:21] = 9'b010000000;
            2: ri[29:24] = 6'd0;
            3: ri[31:30] = 2'b11;
            default: ;
         endcase
         run_instr(ri, 4'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 5), "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
